// File: rtl/dmem_pkg.sv
// Shared constants, FSM state and response payload for the byte-addressed data memory LSU.
package dmem_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned XLEN      = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } dmem_state_e;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] rdata;
    } dmem_rsp_t;

endpackage

// File: rtl/data_memory_align.sv
// Combinational lane steering: store byte-enables/shifted data, load extraction/extension,
// and misalignment / illegal-funct3 detection.
module data_memory_align
    import dmem_pkg::*;
(
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [1:0]           lane,
    input  logic [XLEN-1:0]      wdata,
    input  logic [XLEN-1:0]      rword,
    output logic [NUM_LANES-1:0] be_c,
    output logic [XLEN-1:0]      wdata_c,
    output logic [XLEN-1:0]      rdata_c,
    output logic                 err_c
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] rshift;
    logic            illegal;
    logic            misalign;

    always_comb begin
        shamt    = {lane, 3'b000};
        rshift   = rword >> shamt;
        be_c     = '0;
        wdata_c  = wdata << shamt;
        rdata_c  = '0;
        illegal  = 1'b0;
        misalign = 1'b0;

        // Unsigned variants exist only for loads; 011/110/111 are never legal.
        unique case (funct3)
            F3_B, F3_BU: begin
                illegal = is_store && (funct3 == F3_BU);
                be_c    = 4'b0001 << lane;
                rdata_c = (funct3 == F3_BU) ? XLEN'(rshift[7:0])
                                            : {{24{rshift[7]}}, rshift[7:0]};
            end
            F3_H, F3_HU: begin
                illegal  = is_store && (funct3 == F3_HU);
                misalign = lane[0];
                be_c     = 4'b0011 << lane;
                rdata_c  = (funct3 == F3_HU) ? XLEN'(rshift[15:0])
                                             : {{16{rshift[15]}}, rshift[15:0]};
            end
            F3_W: begin
                misalign = (lane != 2'b00);
                be_c     = 4'b1111;
                rdata_c  = rword;
            end
            default: illegal = 1'b1;
        endcase

        err_c = illegal || misalign;
        if (err_c) begin
            be_c    = '0;
            rdata_c = '0;
        end
    end

endmodule

// File: rtl/data_memory_lsu.sv
// RV32I byte-addressed data memory: valid/ready requests, one-cycle registered response,
// range/alignment checking and an optional post-reset zero-fill.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DEPTH          = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] LAST_IDX  = MEM_AW'(DEPTH - 1);
    localparam dmem_state_e       RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    dmem_state_e         state_q, state_d;
    logic [MEM_AW-1:0]   clr_idx_q, clr_idx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    dmem_rsp_t           rsp_q, rsp_d;

    logic [BYTE_W-1:0]    mem_q [NUM_LANES][DEPTH];
    logic [NUM_LANES-1:0] mem_we;
    logic [MEM_AW-1:0]    mem_widx;
    logic [XLEN-1:0]      mem_wdata;

    logic [IDX_W-1:0]     word_idx;
    logic [MEM_AW-1:0]    mem_idx;
    logic [XLEN-1:0]      rword;
    logic                 range_err;
    logic                 accept;
    logic                 req_err;

    logic [NUM_LANES-1:0] al_be;
    logic [XLEN-1:0]      al_wdata;
    logic [XLEN-1:0]      al_rdata;
    logic                 al_err;

    assign word_idx  = req_addr[ADDR_W-1:2];
    assign mem_idx   = MEM_AW'(word_idx);
    assign range_err = (32'(word_idx) >= DEPTH);
    assign accept    = req_valid && ready_q;
    assign req_err   = al_err || range_err;

    // Asynchronous read so a load sees a store committed on the previous edge.
    always_comb begin
        rword = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            rword[l*BYTE_W +: BYTE_W] = mem_q[l][mem_idx];
        end
    end

    data_memory_align u_align (
        .is_store (req_we),
        .funct3   (req_funct3),
        .lane     (req_addr[1:0]),
        .wdata    (req_wdata),
        .rword    (rword),
        .be_c     (al_be),
        .wdata_c  (al_wdata),
        .rdata_c  (al_rdata),
        .err_c    (al_err)
    );

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rsp_valid_d = accept;
        rsp_d       = rsp_q;
        mem_we      = '0;
        mem_widx    = mem_idx;
        mem_wdata   = al_wdata;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = '1;
                mem_widx  = clr_idx_q;
                mem_wdata = '0;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + MEM_AW'(1);
                end
            end
            ST_IDLE: begin
                if (accept && req_we && !req_err) begin
                    mem_we = al_be;
                end
            end
            default: state_d = RST_STATE;
        endcase

        if (accept) begin
            rsp_d.err   = req_err;
            rsp_d.rdata = (req_we || req_err) ? '0 : al_rdata;
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            clr_idx_q   <= '0;
            ready_q     <= 1'b0;
            busy_q      <= CLEAR_ON_RESET;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // Storage array is not reset; zero-fill is done by the CLEAR sequence.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (mem_we[l]) begin
                mem_q[l][mem_widx] <= mem_wdata[l*BYTE_W +: BYTE_W];
            end
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu with DEPTH=16 and zero-fill enabled.
module tb_data_memory_lsu;
    import dmem_pkg::*;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    data_memory_lsu #(
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, ".rsp_rdata"}, rsp_rdata,      32'd0);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd1);
    endtask

    // Called just after reset release; counts edges until req_ready rises.
    task automatic wait_clear(input string tag);
        int cnt = 0;
        chk({tag, ".busy_start"},  32'(busy),      32'd1);
        chk({tag, ".ready_start"}, 32'(req_ready), 32'd0);
        while (!req_ready && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, ".len"},       32'(cnt),       32'(DEPTH));
        chk({tag, ".busy_end"},  32'(busy),      32'd0);
    endtask

    task automatic req(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rdata"}, rsp_rdata,      exp_rd);
        chk({tag, ".err"},   32'(rsp_err),   32'(exp_err));
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        #12;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        wait_clear("clr0");

        req(1'b0, F3_W, 16'h003C, 32'h0, 32'h0000_0000, 1'b0, "lw_3c_cleared");

        req(1'b1, F3_W,  16'h0000, 32'h80FF_7F01, 32'h0, 1'b0, "sw_0");
        req(1'b0, F3_B,  16'h0000, 32'h0, 32'h0000_0001, 1'b0, "lb_0");
        req(1'b0, F3_B,  16'h0002, 32'h0, 32'hFFFF_FFFF, 1'b0, "lb_2");
        req(1'b0, F3_BU, 16'h0002, 32'h0, 32'h0000_00FF, 1'b0, "lbu_2");
        req(1'b0, F3_B,  16'h0003, 32'h0, 32'hFFFF_FF80, 1'b0, "lb_3");
        req(1'b0, F3_H,  16'h0002, 32'h0, 32'hFFFF_80FF, 1'b0, "lh_2");
        req(1'b0, F3_HU, 16'h0000, 32'h0, 32'h0000_7F01, 1'b0, "lhu_0");
        req(1'b0, F3_BU, 16'h0001, 32'h0, 32'h0000_007F, 1'b0, "lbu_1");

        req(1'b1, F3_W, 16'h0004, 32'h1122_3344, 32'h0, 1'b0, "sw_4");
        req(1'b1, F3_B, 16'h0005, 32'h0000_00AA, 32'h0, 1'b0, "sb_5");
        req(1'b1, F3_H, 16'h0006, 32'h0000_BEEF, 32'h0, 1'b0, "sh_6");
        req(1'b0, F3_W, 16'h0004, 32'h0, 32'hBEEF_AA44, 1'b0, "lw_4");

        req(1'b0, F3_H,   16'h0001, 32'h0,         32'h0, 1'b1, "lh_mis");
        req(1'b1, F3_W,   16'h0006, 32'hDEAD_BEEF, 32'h0, 1'b1, "sw_mis");
        req(1'b0, F3_W,   16'h0040, 32'h0,         32'h0, 1'b1, "lw_oor");
        req(1'b0, 3'b011, 16'h0000, 32'h0,         32'h0, 1'b1, "ld_f3_011");
        req(1'b1, 3'b100, 16'h0004, 32'h0000_00FF, 32'h0, 1'b1, "st_f3_100");
        req(1'b1, F3_W,   16'h0044, 32'hCAFE_F00D, 32'h0, 1'b1, "sw_oor");
        req(1'b0, F3_W,   16'h0004, 32'h0, 32'hBEEF_AA44, 1'b0, "lw_4_intact");

        // Back-to-back store then load to the same word.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 16'h0008;
        req_wdata  = 32'h1234_5678;
        chk("b2b.ready0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b.st_valid", 32'(rsp_valid), 32'd1);
        chk("b2b.ready1",   32'(req_ready), 32'd1);
        req_we = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b.ld_valid", 32'(rsp_valid), 32'd1);
        chk("b2b.ld_rdata", rsp_rdata,      32'h1234_5678);
        chk("b2b.ld_err",   32'(rsp_err),   32'd0);
        chk("b2b.ready2",   32'(req_ready), 32'd1);

        // Reset while a load response is on the outputs.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 16'h0004;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("pend.valid", 32'(rsp_valid), 32'd1);
        chk("pend.rdata", rsp_rdata,      32'hBEEF_AA44);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_rsp");

        // Reset again in the middle of the zero-fill.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_clr.busy",  32'(busy),      32'd1);
        chk("mid_clr.ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_clr");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        wait_clear("clr2");
        req(1'b0, F3_W, 16'h0004, 32'h0, 32'h0000_0000, 1'b0, "lw_4_recleared");
        req(1'b0, F3_W, 16'h0008, 32'h0, 32'h0000_0000, 1'b0, "lw_8_recleared");
        req(1'b0, F3_W, 16'h0000, 32'h0, 32'h0000_0000, 1'b0, "lw_0_recleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
